minicpu_data_bridge: RTL and testbench
======================================

// Module: minicpu_data_bridge
// PURPOSE
//  Sits directly downstream of the miniCPU data port (data_sram_we/addr/wdata/rdata).
//  Decodes each access: the confreg window goes to on-chip registers, every other address passes through to data SRAM.
//  On-chip registers: LED output, synchronised switches, free-running timer, and a UART TX FIFO with a valid/ready drain.
//  Read data is combinational (zero latency) because the CPU completes loads in the same cycle; writes commit at posedge clk.
// PARAMETERS
//  CONF_BASE   32'hBFAF_0000  base of the 64 KiB confreg window (addr[31:16] compared)
//  FIFO_DEPTH  8              TX FIFO entries, power of two, >=2
//  LED_W       16             LED register width
//  SW_W        8              switch input width
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  cpu_we         in   1      CPU store strobe (one cycle per st_w)
//  cpu_addr       in   32     CPU byte address (word aligned)
//  cpu_wdata      in   32     store data
//  cpu_rdata      out  32     load data, combinational
//  ram_we         out  1      data SRAM write enable
//  ram_addr       out  32     data SRAM address
//  ram_wdata      out  32     data SRAM write data
//  ram_rdata      in   32     data SRAM read data
//  led            out  LED_W  LED register
//  sw             in   SW_W   asynchronous switches
//  tx_data        out  8      FIFO head byte
//  tx_valid       out  1      FIFO non-empty
//  tx_ready       in   1      consumer accepts head when tx_valid&tx_ready
// BEHAVIOUR
//  - hit = (cpu_addr[31:16]==CONF_BASE[31:16]); ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we&~hit.
//  - Offsets (addr[15:0]): F000 LED RW; F004 SW RO; E000 TIMER RW; F010 TXDATA WO; F014 TXSTAT RW.
//  - cpu_rdata = hit ? reg mux : ram_rdata. Unmapped in-window offsets read 0; writes to them ignored.
//  - Reset values: led=0, timer=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0, sw sync flops=0.
//  - LED: zero-extended on read; write takes cpu_wdata[LED_W-1:0] at the edge.
//  - SW: two-flop synchroniser; read returns the second stage, zero-extended; 2-cycle latency from pin.
//  - TIMER: +1 every cycle, wraps FFFF_FFFF->0; a write loads cpu_wdata (write beats increment that cycle); next cycle reads wdata+1.
//  - TXDATA write pushes cpu_wdata[7:0]; read returns 0. Push while full: data dropped, overflow<=1.
//  - Pop on tx_valid&tx_ready; head advances next edge. Push and pop same cycle: both happen, count unchanged (including when full).
//  - TXSTAT read: {count[..],bit2 overflow,bit1 empty,bit0 full}, count in bits[15:8]. Write with wdata[2]=1 clears overflow (write-1-to-clear).
//  - tx_data stable while tx_valid&~tx_ready. Pointers wrap mod FIFO_DEPTH; count 0..FIFO_DEPTH.
//  - Reset mid-operation flushes the FIFO and drops any byte being presented. A store in the reset cycle has no register effect; RAM passthrough is unaffected.
// CONFIGURATION
//  MINICPU_BRIDGE_TIMER_CMP_EN defined: adds TIMER_CMP at E004 (RW, reset FFFF_FFFF) and sticky flag TXSTAT bit3 = set when timer==cmp.
//    Writing 1 to TXSTAT bit3 clears it; set wins over clear in the same cycle.
//  Undefined: E004 is unmapped (reads 0) and bit3 reads 0.
// STRUCTURE
//  Package minicpu_bridge_pkg: CONF_BASE default, offset localparams, TXSTAT bit indices.
//  One sub-module, minicpu_tx_fifo (sync FIFO with push/pop/full/empty/count); decode and registers stay in the top.
// TESTING
//  1. reset, then st_w 0x1C000100<=0x12345678, ld_w same -> ram_we=1 once, cpu_rdata=0x12345678, led unchanged.
//  2. st_w BFAFF000<=0xFFFFA5A5 -> led=0xA5A5 next cycle; ld_w BFAFF000 -> 0x0000A5A5.
//  3. st_w BFAFE000<=0xFFFFFFFE, idle 3 cycles, read -> 0x00000001 (wrap verified).
//  4. tx_ready=0, push 9 bytes (FIFO_DEPTH=8) -> TXSTAT=0x0805, tx_data=first byte; st_w TXSTAT<=4 -> 0x0801.
//  5. FIFO full, push with tx_ready=1 in the same cycle -> count stays 8, no overflow, order preserved.
//  6. sw=0x3C -> SW reads 0x3C from the 2nd cycle after the edge; reset asserted with 3 bytes queued -> tx_valid=0 and TXSTAT=0x0002 next cycle.

Source files
------------

// File: rtl/minicpu_bridge_pkg.sv
// rtl/minicpu_bridge_pkg.sv - shared constants and offset decode for the miniCPU data bridge
package minicpu_bridge_pkg;

  localparam logic [31:0] CONF_BASE_DEF = 32'hBFAF_0000;

  localparam logic [15:0] OFF_LED       = 16'hF000;
  localparam logic [15:0] OFF_SW        = 16'hF004;
  localparam logic [15:0] OFF_TIMER     = 16'hE000;
  localparam logic [15:0] OFF_TIMER_CMP = 16'hE004;
  localparam logic [15:0] OFF_TXDATA    = 16'hF010;
  localparam logic [15:0] OFF_TXSTAT    = 16'hF014;

  localparam int TXSTAT_FULL    = 0;
  localparam int TXSTAT_EMPTY   = 1;
  localparam int TXSTAT_OVF     = 2;
  localparam int TXSTAT_CMP     = 3;
  localparam int TXSTAT_CNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_SW,
    SEL_TIMER,
    SEL_TIMER_CMP,
    SEL_TXDATA,
    SEL_TXSTAT
  } reg_sel_e;

  // TIMER_CMP only decodes when the compare feature is built in.
  function automatic reg_sel_e decode_off(input logic [15:0] off, input logic cmp_en);
    case (off)
      OFF_LED:       return SEL_LED;
      OFF_SW:        return SEL_SW;
      OFF_TIMER:     return SEL_TIMER;
      OFF_TIMER_CMP: return cmp_en ? SEL_TIMER_CMP : SEL_NONE;
      OFF_TXDATA:    return SEL_TXDATA;
      OFF_TXSTAT:    return SEL_TXSTAT;
      default:       return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/minicpu_tx_fifo.sv
// rtl/minicpu_tx_fifo.sv - synchronous byte FIFO; a push into a full FIFO is kept only if a pop frees a slot
module minicpu_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_ok, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign count_o = cnt_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    if (push_ok) wr_d = wr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/minicpu_data_bridge.sv
// rtl/minicpu_data_bridge.sv - miniCPU data-port decoder: confreg window registers plus SRAM passthrough
// MINICPU_BRIDGE_TIMER_CMP_EN adds TIMER_CMP at E004 and the sticky compare flag in TXSTAT bit3.
module minicpu_data_bridge
  import minicpu_bridge_pkg::*;
#(
  parameter logic [31:0] CONF_BASE  = CONF_BASE_DEF,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LED_W      = 16,
  parameter int          SW_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             ram_we,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef MINICPU_BRIDGE_TIMER_CMP_EN
  localparam logic CMP_EN = 1'b1;
`else
  localparam logic CMP_EN = 1'b0;
`endif

  logic           hit, wr;
  reg_sel_e       sel;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]    timer_q, timer_d;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;
  logic           ovf_q, ovf_d;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]  fifo_count;
  logic           cmp_flag;
  logic [31:0]    cmp_rd;
  logic [31:0]    txstat, reg_rdata;

  assign hit       = (cpu_addr[31:16] == CONF_BASE[31:16]);
  assign sel       = decode_off(cpu_addr[15:0], CMP_EN);
  assign wr        = cpu_we & hit;
  assign ram_we    = cpu_we & ~hit;
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign led       = led_q;

  assign fifo_push = wr & (sel == SEL_TXDATA);
  assign fifo_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~fifo_empty;

  minicpu_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (cpu_wdata[7:0]),
    .dout_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

  // A store beats the increment, so the loaded value reads back +1 a cycle later.
  always_comb begin
    led_d   = led_q;
    timer_d = timer_q + 32'd1;
    ovf_d   = ovf_q;
    if (wr && sel == SEL_LED)   led_d   = cpu_wdata[LED_W-1:0];
    if (wr && sel == SEL_TIMER) timer_d = cpu_wdata;
    if (wr && sel == SEL_TXSTAT && cpu_wdata[TXSTAT_OVF]) ovf_d = 1'b0;
    if (fifo_drop)              ovf_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      timer_q   <= '0;
      ovf_q     <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      timer_q   <= timer_d;
      ovf_q     <= ovf_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef MINICPU_BRIDGE_TIMER_CMP_EN
  logic [31:0] cmp_q, cmp_d;
  logic        cmp_flag_q, cmp_flag_d;

  // Set has priority over a same-cycle write-1-to-clear.
  always_comb begin
    cmp_d      = cmp_q;
    cmp_flag_d = cmp_flag_q;
    if (wr && sel == SEL_TIMER_CMP) cmp_d = cpu_wdata;
    if (wr && sel == SEL_TXSTAT && cpu_wdata[TXSTAT_CMP]) cmp_flag_d = 1'b0;
    if (timer_q == cmp_q) cmp_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q      <= 32'hFFFF_FFFF;
      cmp_flag_q <= 1'b0;
    end else begin
      cmp_q      <= cmp_d;
      cmp_flag_q <= cmp_flag_d;
    end
  end

  assign cmp_flag = cmp_flag_q;
  assign cmp_rd   = cmp_q;
`else
  assign cmp_flag = 1'b0;
  assign cmp_rd   = '0;
`endif

  always_comb begin
    txstat                            = '0;
    txstat[TXSTAT_CNT_LSB +: CW]      = fifo_count;
    txstat[TXSTAT_CMP]                = cmp_flag;
    txstat[TXSTAT_OVF]                = ovf_q;
    txstat[TXSTAT_EMPTY]              = fifo_empty;
    txstat[TXSTAT_FULL]               = fifo_full;
  end

  always_comb begin
    reg_rdata = '0;
    case (sel)
      SEL_LED:       reg_rdata = 32'(led_q);
      SEL_SW:        reg_rdata = 32'(sw_sync_q);
      SEL_TIMER:     reg_rdata = timer_q;
      SEL_TIMER_CMP: reg_rdata = cmp_rd;
      SEL_TXSTAT:    reg_rdata = txstat;
      default:       reg_rdata = '0;
    endcase
  end

  assign cpu_rdata = hit ? reg_rdata : ram_rdata;

endmodule

// File: tb/tb_minicpu_data_bridge.sv
// tb/tb_minicpu_data_bridge.sv - randomized self-checking bench for minicpu_data_bridge
module tb_minicpu_data_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [15:0] led;
  logic [7:0]  sw;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  minicpu_data_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .led       (led),
    .sw        (sw),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain state plus a queue for the TX FIFO.
  logic [31:0] m_timer = '0;
  logic [31:0] m_cmp   = 32'hFFFF_FFFF;
  logic [15:0] m_led   = '0;
  logic [7:0]  m_sw1   = '0;
  logic [7:0]  m_sw2   = '0;
  bit          m_ovf   = 1'b0;
  bit          m_flag  = 1'b0;
  logic [7:0]  m_q [$];
  logic [31:0] m_ram [logic [31:0]];

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return m_ram.exists(a) ? m_ram[a] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_reg(input logic [15:0] o);
    int sz;
    sz = m_q.size();
    case (o)
      16'hF000: return {16'h0, m_led};
      16'hF004: return {24'h0, m_sw2};
      16'hE000: return m_timer;
`ifdef MINICPU_BRIDGE_TIMER_CMP_EN
      16'hE004: return m_cmp;
`endif
      16'hF014: return (32'(sz) << 8) | (32'(m_flag) << 3) | (32'(m_ovf) << 2)
                       | ((sz == 0) ? 32'h2 : 32'h0) | ((sz == 8) ? 32'h1 : 32'h0);
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic        h, w, pop, push;
    logic [15:0] o;
    int          sz;
    h = (cpu_addr[31:16] == 16'hBFAF);
    o = cpu_addr[15:0];
    w = cpu_we && h;
    if (cpu_we && !h) m_ram[cpu_addr] = cpu_wdata;
    if (reset) begin
      m_timer = '0; m_cmp = 32'hFFFF_FFFF; m_led = '0; m_sw1 = '0; m_sw2 = '0;
      m_ovf = 1'b0; m_flag = 1'b0; m_q.delete();
    end else begin
      sz   = m_q.size();
      pop  = (sz > 0) && tx_ready;
      push = w && (o == 16'hF010);
`ifdef MINICPU_BRIDGE_TIMER_CMP_EN
      if (w && o == 16'hF014 && cpu_wdata[3]) m_flag = 1'b0;
      if (m_timer == m_cmp) m_flag = 1'b1;
      if (w && o == 16'hE004) m_cmp = cpu_wdata;
`endif
      m_timer = (w && o == 16'hE000) ? cpu_wdata : m_timer + 32'd1;
      if (w && o == 16'hF000) m_led = cpu_wdata[15:0];
      if (w && o == 16'hF014 && cpu_wdata[2]) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (sz < 8 || pop) m_q.push_back(cpu_wdata[7:0]);
        else m_ovf = 1'b1;
      end
      m_sw2 = m_sw1;
      m_sw1 = sw;
    end
  end

  // Compare process: every output is meaningful on every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      logic h;
      h = (cpu_addr[31:16] == 16'hBFAF);
      chk("ram_we", {31'h0, ram_we}, {31'h0, cpu_we & ~h});
      chk("ram_addr", ram_addr, cpu_addr);
      chk("ram_wdata", ram_wdata, cpu_wdata);
      chk("cpu_rdata", cpu_rdata, h ? exp_reg(cpu_addr[15:0]) : ram_read(cpu_addr));
      chk("led", {16'h0, led}, {16'h0, m_led});
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() > 0});
      chk("tx_data", {24'h0, tx_data}, (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0);
    end
  end

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    ram_rdata = ram_read(a);
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; tx_ready = 1'b0; sw = 8'h00;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; ram_rdata = '0;
    @(posedge clk);
    chk_on = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    cyc(0, 32'hBFAF_F014, 0);
    chk("rst_txstat", cpu_rdata, 32'h0000_0002);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    adv();
    cyc(0, 32'hBFAF_E000, 0);
    chk("rst_timer", cpu_rdata, 32'h1);
    adv();

    // RAM passthrough
    cyc(1, 32'h1C00_0100, 32'h1234_5678);
    chk("t1_ram_we", {31'h0, ram_we}, 32'h1);
    adv();
    cyc(0, 32'h1C00_0100, 0);
    chk("t1_rdata", cpu_rdata, 32'h1234_5678);
    chk("t1_ram_we_ld", {31'h0, ram_we}, 32'h0);
    chk("t1_led", {16'h0, led}, 32'h0);
    adv();

    // LED
    cyc(1, 32'hBFAF_F000, 32'hFFFF_A5A5);
    chk("t2_ram_we", {31'h0, ram_we}, 32'h0);
    adv();
    cyc(0, 32'hBFAF_F000, 0);
    chk("t2_led", {16'h0, led}, 32'h0000_A5A5);
    chk("t2_rdata", cpu_rdata, 32'h0000_A5A5);
    adv();

    // timer wrap
    cyc(1, 32'hBFAF_E000, 32'hFFFF_FFFE); adv();
    for (int i = 0; i < 3; i++) begin cyc(0, 32'h0, 0); adv(); end
    cyc(0, 32'hBFAF_E000, 0);
    chk("t3_timer_wrap", cpu_rdata, 32'h0000_0001);
    adv();

    // overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin cyc(1, 32'hBFAF_F010, 32'h40 + i); adv(); end
    cyc(0, 32'hBFAF_F014, 0);
    chk("t4_txstat_full_ovf", cpu_rdata, 32'h0000_0805);
    chk("t4_tx_data", {24'h0, tx_data}, 32'h40);
    adv();
    cyc(1, 32'hBFAF_F014, 32'h4); adv();
    cyc(0, 32'hBFAF_F014, 0);
    chk("t4_ovf_clear", cpu_rdata, 32'h0000_0801);
    adv();

    // push and pop while full
    tx_ready = 1'b1;
    cyc(1, 32'hBFAF_F010, 32'h99);
    chk("t5_head", {24'h0, tx_data}, 32'h40);
    adv();
    tx_ready = 1'b0;
    cyc(0, 32'hBFAF_F014, 0);
    chk("t5_txstat", cpu_rdata, 32'h0000_0801);
    adv();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 32'h0, 0);
      chk("t5_drain", {24'h0, tx_data}, (i < 7) ? 32'h41 + i : 32'h99);
      adv();
    end
    cyc(0, 32'hBFAF_F014, 0);
    chk("t5_empty", cpu_rdata, 32'h0000_0002);
    adv();

    // switch synchroniser
    tx_ready = 1'b0;
    sw = 8'h3C;
    cyc(0, 32'hBFAF_F004, 0); adv();
    cyc(0, 32'hBFAF_F004, 0);
    chk("t6_sw_1cyc", cpu_rdata, 32'h0);
    adv();
    cyc(0, 32'hBFAF_F004, 0);
    chk("t6_sw_2cyc", cpu_rdata, 32'h3C);
    adv();

    // reset with bytes queued, plus a push in the reset cycle
    for (int i = 0; i < 3; i++) begin cyc(1, 32'hBFAF_F010, 32'h10 + i); adv(); end
    reset = 1'b1;
    cyc(1, 32'hBFAF_F010, 32'h77); adv();
    reset = 1'b0;
    cyc(0, 32'hBFAF_F014, 0);
    chk("t6_rst_txstat", cpu_rdata, 32'h0000_0002);
    chk("t6_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    adv();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      reset = ($urandom_range(0, 249) == 0);
      tx_ready = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       a = {16'h1C00, 14'($urandom), 2'b00};
        1:       a = 32'hBFAF_F000;
        2:       a = 32'hBFAF_F004;
        3:       a = 32'hBFAF_E000;
        4:       a = 32'hBFAF_E004;
        5, 6:    a = 32'hBFAF_F010;
        7:       a = 32'hBFAF_F014;
        8:       a = {16'hBFAF, 14'($urandom), 2'b00};
        default: a = {28'h1C00_010, 2'($urandom), 2'b00};
      endcase
      cyc(1'($urandom), a, $urandom);
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
